// File: rtl/fma_seq_pkg.sv
// Shared definitions for the fma sequencer: core-state codes, Q1.15 width,
// and the sequencer FSM state encoding.
package fma_seq_pkg;

    localparam int Q15_BITS = 16;

    localparam logic [2:0] CORE_IDLE = 3'b000;
    localparam logic [2:0] CORE_WAIT = 3'b100;
    localparam logic [2:0] CORE_EXEC = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ISSUE,
        ST_CAPTURE,
        ST_RESULT
    } seq_state_e;

endpackage

// File: rtl/fma_seq.sv
// Dot-product sequencer: streams operand pairs into an external fma unit one
// element at a time and returns the accumulated Q1.15 result.
module fma_seq
    import fma_seq_pkg::*;
#(
    parameter int DATA_BITS = Q15_BITS,
    parameter int LEN_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 start,
    input  logic [LEN_BITS-1:0]  len,
    input  logic [DATA_BITS-1:0] bias,
    input  logic                 op_valid,
    output logic                 op_ready,
    input  logic [DATA_BITS-1:0] op_rs,
    input  logic [DATA_BITS-1:0] op_rt,
    output logic [2:0]           fma_core_state,
    output logic                 fma_enable,
    output logic [DATA_BITS-1:0] fma_rs,
    output logic [DATA_BITS-1:0] fma_rt,
    output logic [DATA_BITS-1:0] fma_rq,
    input  logic [DATA_BITS-1:0] fma_out,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [DATA_BITS-1:0] res_data,
    output logic                 busy
);

    seq_state_e           state;
    logic [DATA_BITS-1:0] acc;
    logic [LEN_BITS-1:0]  cnt;
    logic                 op_ready_q;
    logic                 res_valid_q;
    logic                 fma_enable_q;

    // Handshake and issue strobes are masked while frozen so no transfer
    // can complete against a held state.
    assign op_ready   = op_ready_q & enable;
    assign res_valid  = res_valid_q & enable;
    assign fma_enable = fma_enable_q & enable;
    assign fma_rq     = acc;
    assign res_data   = acc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            acc            <= '0;
            cnt            <= '0;
            fma_rs         <= '0;
            fma_rt         <= '0;
            op_ready_q     <= 1'b0;
            res_valid_q    <= 1'b0;
            fma_enable_q   <= 1'b0;
            busy           <= 1'b0;
            fma_core_state <= CORE_IDLE;
        end else if (enable) begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        cnt            <= len;
                        acc            <= bias;
                        busy           <= 1'b1;
                        fma_core_state <= CORE_WAIT;
                        if (len == '0) begin
                            state       <= ST_RESULT;
                            res_valid_q <= 1'b1;
                        end else begin
                            state      <= ST_LOAD;
                            op_ready_q <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (op_valid) begin
                        fma_rs         <= op_rs;
                        fma_rt         <= op_rt;
                        op_ready_q     <= 1'b0;
                        fma_enable_q   <= 1'b1;
                        fma_core_state <= CORE_EXEC;
                        state          <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    fma_enable_q   <= 1'b0;
                    fma_core_state <= CORE_WAIT;
                    state          <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    // cnt is at least 1 here, so the decrement never wraps.
                    acc <= fma_out;
                    cnt <= cnt - 1'b1;
                    if (cnt == LEN_BITS'(1)) begin
                        state       <= ST_RESULT;
                        res_valid_q <= 1'b1;
                    end else begin
                        state      <= ST_LOAD;
                        op_ready_q <= 1'b1;
                    end
                end
                ST_RESULT: begin
                    if (res_ready) begin
                        res_valid_q    <= 1'b0;
                        busy           <= 1'b0;
                        fma_core_state <= CORE_IDLE;
                        state          <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
